// File: rtl/stack_cache_sequencer_pkg.sv
// Shared BeeF definitions: the control-unit phase (STATE) and the stack cache sequencer FSM states.
package definitions;

    typedef enum logic [1:0] {CORE_S, CACHE_SAVE_S, CACHE_LOAD_S} STATE;

    typedef enum logic [1:0] {IDLE, SAVE, SHIFT, LOAD} seq_state_e;

    // Phase reported to the control unit so it picks the load or save control bundles.
    function automatic STATE phase_of(input seq_state_e s);
        case (s)
            SAVE, SHIFT: return CACHE_SAVE_S;
            LOAD:        return CACHE_LOAD_S;
            default:     return CORE_S;
        endcase
    endfunction

endpackage

// File: rtl/stack_cache_sequencer_if.sv
// Main-memory burst port of the stack cache sequencer: req/ack handshake plus beat address and direction.
interface stack_cache_sequencer_if #(
    parameter int ADDR_W = 16
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic              ack;

    modport master (output req, output we, output addr, input ack);
    modport slave  (input req, input we, input addr, output ack);
endinterface

// File: rtl/stack_cache_sequencer_burst_engine.sv
// Beat sequencer for one spill/fill burst: holds mem_req across beats, counts beats, flags the last ack.
module cache_burst_engine #(
    parameter int BURST  = 4,
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_we,
    input  logic              i_ack,
    output logic              o_req,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_done
);
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]  r_beat;
    logic              w_last;

    assign w_last = (r_beat == IDX_W'(BURST - 1));
    assign o_done = r_req & i_ack & w_last;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_req  <= 1'b0;
            r_we   <= 1'b0;
            r_base <= '0;
            r_beat <= '0;
        end else if (i_start) begin
            r_req  <= 1'b1;
            r_we   <= i_we;
            r_base <= i_base;
            r_beat <= '0;
        end else if (r_req && i_ack) begin
            if (w_last) begin
                r_req  <= 1'b0;
                r_beat <= '0;
            end else begin
                r_beat <= r_beat + IDX_W'(1);
            end
        end
    end

    // Outputs are decodes of registered state, so they hold steady until the beat is acked.
    assign o_req  = r_req;
    assign o_we   = r_req & r_we;
    assign o_addr = r_req ? (r_base + ADDR_W'(r_beat)) : '0;
    assign o_idx  = r_req ? r_beat : '0;

endmodule

// File: rtl/stack_cache_sequencer.sv
// Stack cache spill/fill sequencer for the BeeF core: occupancy, spilled-region pointer and core stall.
// Optional macro BEEF_CACHE_STATS_EN adds saturating spill_count / fill_count outputs.
module stack_cache_sequencer
    import definitions::*;
#(
    parameter int CACHE_DEPTH = 8,
    parameter int BURST       = 4,
    parameter int ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push_i,
    input  logic                           pop_i,
    output logic                           stall,
    output STATE                           state_out,
    output logic [$clog2(CACHE_DEPTH):0]   level,
    output logic [$clog2(CACHE_DEPTH)-1:0] cache_idx,
    output logic                           cache_write,
    output logic                           cache_shift,
    stack_cache_sequencer_if.master        mem,
    output logic                           underflow,
    output logic                           overflow
`ifdef BEEF_CACHE_STATS_EN
    ,
    output logic [15:0]                    spill_count,
    output logic [15:0]                    fill_count
`endif
);
    localparam int IDX_W = $clog2(CACHE_DEPTH);
    localparam int LVL_W = IDX_W + 1;
    localparam int SP_W  = ADDR_W + 1;
    localparam int SPX_W = ADDR_W + 2;

    seq_state_e        r_state, w_next_state;
    logic [LVL_W-1:0]  r_level;
    logic [SP_W-1:0]   r_mem_sp;
    logic              r_underflow, r_overflow;

    logic              w_push_only, w_pop_only, w_full, w_empty, w_room, w_sp_zero;
    logic              w_start, w_start_we, w_done, w_set_ovf, w_set_unf;
    logic [ADDR_W-1:0] w_start_base;
    logic [SP_W-1:0]   w_sp_down;

    assign w_push_only = push_i & ~pop_i;
    assign w_pop_only  = pop_i & ~push_i;
    assign w_full      = (r_level == LVL_W'(CACHE_DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_sp_zero   = (r_mem_sp == '0);
    assign w_sp_down   = r_mem_sp - SP_W'(BURST);
    // Widened by one bit so mem_sp + BURST cannot wrap when mem_sp already equals 2^ADDR_W.
    assign w_room      = ({1'b0, r_mem_sp} + SPX_W'(BURST)) <= (SPX_W'(1) << ADDR_W);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        w_next_state = r_state;
        w_start      = 1'b0;
        w_start_we   = 1'b0;
        w_start_base = r_mem_sp[ADDR_W-1:0];
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        stall        = 1'b0;
        cache_write  = 1'b0;
        cache_shift  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_push_only && w_full) begin
                    if (w_room) begin
                        w_next_state = SAVE;
                        w_start      = 1'b1;
                        w_start_we   = 1'b1;
                        stall        = 1'b1;
                    end else begin
                        w_set_ovf = 1'b1;
                    end
                end else if (w_pop_only && w_empty) begin
                    if (w_sp_zero) begin
                        w_set_unf = 1'b1;
                    end else begin
                        w_next_state = LOAD;
                        w_start      = 1'b1;
                        w_start_base = w_sp_down[ADDR_W-1:0];
                        stall        = 1'b1;
                    end
                end
            end
            SAVE: begin
                stall = 1'b1;
                if (w_done) w_next_state = SHIFT;
            end
            SHIFT: begin
                stall        = 1'b1;
                cache_shift  = 1'b1;
                w_next_state = IDLE;
            end
            LOAD: begin
                stall       = 1'b1;
                cache_write = mem.ack;
                if (w_done) w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level     <= '0;
            r_mem_sp    <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_set_ovf) r_overflow  <= 1'b1;
            if (w_set_unf) r_underflow <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_push_only && !w_full)      r_level <= r_level + LVL_W'(1);
                    else if (w_pop_only && !w_empty) r_level <= r_level - LVL_W'(1);
                end
                SHIFT: begin
                    r_level  <= r_level - LVL_W'(BURST);
                    r_mem_sp <= r_mem_sp + SP_W'(BURST);
                end
                LOAD: begin
                    if (w_done) begin
                        r_level  <= LVL_W'(BURST);
                        r_mem_sp <= w_sp_down;
                    end
                end
                default: ;
            endcase
        end
    end

    cache_burst_engine #(
        .BURST (BURST),
        .ADDR_W(ADDR_W),
        .IDX_W (IDX_W)
    ) u_burst (
        .clk    (clk),
        .reset  (reset),
        .i_start(w_start),
        .i_base (w_start_base),
        .i_we   (w_start_we),
        .i_ack  (mem.ack),
        .o_req  (mem.req),
        .o_we   (mem.we),
        .o_addr (mem.addr),
        .o_idx  (cache_idx),
        .o_done (w_done)
    );

    assign state_out = phase_of(r_state);
    assign level     = r_level;
    assign underflow = r_underflow;
    assign overflow  = r_overflow;

`ifdef BEEF_CACHE_STATS_EN
    logic [15:0] r_spill_count, r_fill_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_spill_count <= '0;
            r_fill_count  <= '0;
        end else begin
            if (r_state == SHIFT && r_spill_count != 16'hFFFF) r_spill_count <= r_spill_count + 16'd1;
            if (r_state == LOAD && w_done && r_fill_count != 16'hFFFF) r_fill_count <= r_fill_count + 16'd1;
        end
    end

    assign spill_count = r_spill_count;
    assign fill_count  = r_fill_count;
`endif

endmodule

// File: doc/stack_cache_sequencer.md
# stack_cache_sequencer

Sequences spill and fill bursts between the on-chip stack cache and main memory for the BeeF core. It tracks cache occupancy and the spilled-region pointer, and stalls the core on push-when-full or pop-when-empty. It runs a req/ack burst to memory and reports its phase to the control unit as a `STATE` value, so the control unit selects the load or save control bundles. The block owns no data path; it drives indices, addresses and strobes only.

## Interface
Parameters:
- `CACHE_DEPTH`, 8: cache entries; power of two.
- `BURST`, 4: words per spill/fill; power of two, `BURST <= CACHE_DEPTH`.
- `ADDR_W`, 16: memory address width.

Ports:
- `clk`  in  1: core clock. The block uses one clock.
- `reset`  in  1: synchronous, active-high reset.
- `push_i`  in  1: core requests push; held while `stall` is high.
- `pop_i`  in  1: core requests pop; held while `stall` is high.
- `stall`  out  1: core must hold its current instruction.
- `state_out`  out  `STATE`: `CORE_S` / `CACHE_SAVE_S` / `CACHE_LOAD_S`; feeds the control unit's `state_in`.
- `level`  out  `$clog2(CACHE_DEPTH)+1`: valid cache entries.
- `cache_idx`  out  `$clog2(CACHE_DEPTH)`: cache entry read (save) or written (load).
- `cache_write`  out  1: write memory read data into `cache[cache_idx]`.
- `cache_shift`  out  1: one-cycle pulse; cache shifts down by `BURST` entries.
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: 1 = write (spill), 0 = read (fill).
- `mem_addr`  out  `ADDR_W`: beat address.
- `mem_ack`  in  1: beat complete; read data is valid in the ack cycle.
- `underflow`  out  1: sticky; pop with empty cache and empty memory.
- `overflow`  out  1: sticky; spill would exceed the address space.

## Operation
- State machine states: `IDLE`, `SAVE`, `SHIFT`, `LOAD`.
- `state_out` mapping: `IDLE` gives `CORE_S`; `SAVE` and `SHIFT` give `CACHE_SAVE_S`; `LOAD` gives `CACHE_LOAD_S`.
- Registers: `level`, `mem_sp` (`ADDR_W+1` bits; count of spilled words, always a multiple of `BURST`), `beat` (beat counter), and the two sticky flags.
- In `IDLE`:
  - Push alone with `level < CACHE_DEPTH`: `level` increments.
  - Pop alone with `level > 0`: `level` decrements.
  - Push and pop together: `level` unchanged, no stall, no burst, at any level.
- Push alone with `level == CACHE_DEPTH`:
  - If `mem_sp + BURST > 2^ADDR_W`: set `overflow`, drop the push, stay in `IDLE`.
  - Otherwise go to `SAVE` with `beat = 0`.
- `SAVE`:
  - Drives `mem_req=1`, `mem_we=1`, `mem_addr = mem_sp + beat`, `cache_idx = beat`.
  - Each `mem_ack` increments `beat`.
  - The ack on the last beat moves the FSM to `SHIFT`.
- `SHIFT`:
  - Pulses `cache_shift`; `level -= BURST`; `mem_sp += BURST`.
  - Returns to `IDLE`; the held push is then accepted normally.
- Pop alone with `level == 0`:
  - If `mem_sp == 0`: set `underflow`, drop the pop, no stall.
  - Otherwise go to `LOAD` with `beat = 0`.
- `LOAD`:
  - Drives `mem_req=1`, `mem_we=0`, `mem_addr = mem_sp - BURST + beat`, `cache_idx = beat`.
  - `cache_write = mem_ack`.
  - The ack on the last beat sets `level = BURST`, `mem_sp -= BURST`, and returns to `IDLE`; the held pop is then accepted.
- `stall` is combinational. It is high in any state other than `IDLE`, and in `IDLE` when a spill or fill is about to start.
- Reset values: all outputs and registers are 0, FSM is `IDLE`, `state_out = CORE_S`. Reset mid-burst abandons the burst; `mem_req` is low after that edge and memory contents are not rolled back.

## Timing
- `mem_req`, `mem_we`, `mem_addr` and `cache_idx` are registered-state decodes. They stay stable until acked.
- `mem_req` stays high across beats; a new beat's address appears the cycle after the previous ack.
- Spill with `mem_ack` tied high, push presented at cycle 0:
  - Cycle 0: stall (still in `IDLE`).
  - Cycles 1 to `BURST`: `SAVE`.
  - Cycle `BURST+1`: `SHIFT`.
  - Cycle `BURST+2`: push accepted.
  - Total stall: `BURST+2` cycles.
- Fill with `mem_ack` tied high, pop presented at cycle 0:
  - Cycles 1 to `BURST`: `LOAD`.
  - Cycle `BURST+1`: pop accepted.
  - Total stall: `BURST+1` cycles.
- Each cycle of `mem_ack` low extends the burst by one cycle.

## Configuration
- `BEEF_CACHE_STATS_EN` defined: adds outputs `spill_count` and `fill_count`, 16 bits each, saturating at `0xFFFF`, reset to 0. Each increments once per completed burst, in `SHIFT` and on the last `LOAD` ack respectively.
- Not defined: these ports and their logic are absent.

## Structure
- Shared `definitions` package: the `STATE` enum (already present); add `seq_state_e` (`IDLE`/`SAVE`/`SHIFT`/`LOAD`).
- Sub-module `cache_burst_engine`: owns `beat`, the `mem_req` hold and the last-beat detect. Inputs are start, base address and direction; outputs are `mem_addr`, `cache_idx` and done.

## Test plan
- Depth 8, burst 4, ack high; 9 pushes → stall 6 cycles on push 9; `mem_addr` 0..3 with `mem_we=1`; `cache_shift` once; final `level=5`, `mem_sp=4`.
- From that state, 5 pops then 1 more → fill reads 0..3 with `cache_write` per beat; `level=3` after the pop is accepted; `mem_sp=0`.
- Pop at `level=0`, `mem_sp=0` → `underflow=1`, no `mem_req`, `stall=0`, `level` stays 0.
- Push and pop together at `level=8` → no stall, no `mem_req`, `level=8`.
- Spill with `mem_ack` toggling 1-0-1-0 → `mem_addr` advances only after ack; spill takes 9 cycles.
- Reset asserted at beat 2 of `LOAD` → next cycle `mem_req=0`, `state_out=CORE_S`, `level=0`, flags 0.
